// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame width and
// bit timing constants for a 100 MHz system clock.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int CLK_HZ            = 100_000_000;

    // Clocks per bit, rounded up so 115200 baud gives 869 clocks.
    function automatic int bit_period(input int baud);
        return (CLK_HZ + baud - 1) / baud;
    endfunction

    localparam int BIT_PERIOD_9600    = bit_period(9600);
    localparam int BIT_PERIOD_19200   = bit_period(19200);
    localparam int BIT_PERIOD_38400   = bit_period(38400);
    localparam int BIT_PERIOD_57600   = bit_period(57600);
    localparam int BIT_PERIOD_115200  = bit_period(115200);

    localparam int HALF_PERIOD_9600   = BIT_PERIOD_9600 / 2;
    localparam int HALF_PERIOD_19200  = BIT_PERIOD_19200 / 2;
    localparam int HALF_PERIOD_38400  = BIT_PERIOD_38400 / 2;
    localparam int HALF_PERIOD_57600  = BIT_PERIOD_57600 / 2;
    localparam int HALF_PERIOD_115200 = BIT_PERIOD_115200 / 2;

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Brings the asynchronous rx line into the clk domain and flags a
// high-to-low transition of the synchronized line.
module uart_rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Synchronizer chain plus one extra flop holding the previous synced value;
    // all reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rx_sync = sync_reg[SYNC_STAGES-1];
    assign rx_fall = prev_reg & ~rx_sync;

endmodule

// File: rtl/uart_rx_with_mcu.sv
// 8N1 UART receiver: starts the baud generator on a start edge, samples each
// bit on its mid-bit tick and reports the byte or a framing error.
module uart_rx_with_mcu
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    logic rx_sync;
    logic rx_fall;

    uart_rx_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rx_sync(rx_sync),
        .rx_fall(rx_fall)
    );

    uart_state_t            state_reg, state_next;
    logic [CNT_W-1:0]       bitcnt_reg, bitcnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic                   bps_reg, bps_next;
    logic                   valid_reg, valid_next;
    logic                   err_reg, err_next;
    logic                   tick;

    // Ticks only count while this receiver has the baud generator running.
    assign tick = clk_bps & bps_reg;

    // State and registered outputs; reset aborts any frame without a strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            bitcnt_reg <= '0;
            shift_reg  <= '0;
            data_reg   <= '0;
            bps_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bitcnt_reg <= bitcnt_next;
            shift_reg  <= shift_next;
            data_reg   <= data_next;
            bps_reg    <= bps_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
        end
    end

    // Next-state and next-output logic for the frame receiver.
    always_comb begin
        state_next  = state_reg;
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        data_next   = data_reg;
        bps_next    = bps_reg;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                bps_next = 1'b0;
                if (rx_fall) begin
                    state_next = START;
                    bps_next   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_sync) begin
                        state_next  = DATA;
                        bitcnt_next = '0;
                    end else begin
                        // Line was high again at mid-start: treat as a glitch.
                        state_next = IDLE;
                        bps_next   = 1'b0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    // LSB arrives first, so shift in at the MSB end.
                    shift_next  = {rx_sync, shift_reg[DATA_BITS-1:1]};
                    bitcnt_next = bitcnt_reg + 1'b1;
                    if (bitcnt_reg == CNT_W'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_sync) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = IDLE;
                    bps_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                bps_next   = 1'b0;
            end
        endcase
    end

    assign bps_start = bps_reg;
    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = err_reg;
    assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_with_mcu.sv
// Directed bench for uart_rx_with_mcu with a behavioural 115200-baud tick
// generator in front of it.
module tb_uart_rx_with_mcu;
    import uart_pkg::*;

    localparam int BIT  = BIT_PERIOD_115200;
    localparam int HALF = HALF_PERIOD_115200;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    logic        gen_tick;
    logic        bps_force;
    logic [15:0] gen_cnt;

    int checks   = 0;
    int failures = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    logic [7:0] data_q[$];

    uart_rx_with_mcu #(
        .DATA_BITS(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .clk_bps  (clk_bps),
        .bps_start(bps_start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud generator: counter held at zero until enabled, tick at mid-bit.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_cnt  <= '0;
            gen_tick <= 1'b0;
        end else begin
            gen_tick <= bps_start && (gen_cnt == 16'(HALF));
            if (!bps_start || gen_cnt == 16'(BIT - 1)) gen_cnt <= '0;
            else gen_cnt <= gen_cnt + 16'd1;
        end
    end
    assign clk_bps = gen_tick | bps_force;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            data_q.push_back(rx_data);
        end
        if (frame_err) err_cnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold_bit(input logic level);
        rx = level;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        if (data_q.size() == 0) begin
            check_eq(tag, 32'hDEAD, {24'd0, exp});
        end else begin
            got = data_q.pop_front();
            check_eq(tag, {24'd0, got}, {24'd0, exp});
        end
    endtask

    initial begin
        int v0;
        int e0;
        rst       = 1'b0;
        rx        = 1'b1;
        bps_force = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_bps_start", {31'd0, bps_start}, 32'd0);
        check_eq("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("reset_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("reset_strobes", {30'd0, rx_valid, frame_err}, 32'd0);
        rst = 1'b1;
        repeat (20) @(posedge clk);

        // Single good frame.
        send_frame(8'hA5, 1'b1);
        @(negedge clk);
        check_eq("a5_valid_count", valid_cnt, 1);
        expect_byte("a5_data", 8'hA5);
        check_eq("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check_eq("a5_no_err", err_cnt, 0);
        check_eq("a5_bps_low", {31'd0, bps_start}, 32'd0);
        check_eq("a5_busy_low", {31'd0, rx_busy}, 32'd0);

        // Back-to-back frames, no idle gap.
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        @(negedge clk);
        check_eq("b2b_valid_count", valid_cnt - v0, 3);
        expect_byte("b2b_data0", 8'h00);
        expect_byte("b2b_data1", 8'hFF);
        expect_byte("b2b_data2", 8'h55);

        // Framing error, line held low, then recovery.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        check_eq("ferr_count", err_cnt - e0, 1);
        check_eq("ferr_no_valid", valid_cnt - v0, 0);
        check_eq("ferr_data_kept", {24'd0, rx_data}, 32'h55);
        check_eq("ferr_idle_while_low", {31'd0, rx_busy}, 32'd0);
        rx = 1'b1;
        repeat (50) @(posedge clk);
        send_frame(8'h12, 1'b1);
        @(negedge clk);
        check_eq("recover_valid_count", valid_cnt - v0, 1);
        expect_byte("recover_data", 8'h12);

        // Short glitch on an idle line.
        v0 = valid_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check_eq("glitch_bps_high", {31'd0, bps_start}, 32'd1);
        rx = 1'b1;
        repeat (500) @(posedge clk);
        @(negedge clk);
        check_eq("glitch_bps_low", {31'd0, bps_start}, 32'd0);
        check_eq("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        check_eq("glitch_no_strobe", (valid_cnt - v0) + (err_cnt - e0), 0);
        check_eq("glitch_data_kept", {24'd0, rx_data}, 32'h12);

        // Reset in the middle of data bit 4 of 0x81.
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(i == 0);
        rx = 1'b0;
        repeat (HALF) @(posedge clk);
        @(negedge clk);
        check_eq("midframe_busy", {31'd0, rx_busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_bps", {31'd0, bps_start}, 32'd0);
        check_eq("async_rst_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("async_rst_data", {24'd0, rx_data}, 32'd0);
        check_eq("async_rst_strobes", {30'd0, rx_valid, frame_err}, 32'd0);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        v0 = valid_cnt;
        send_frame(8'h7E, 1'b1);
        @(negedge clk);
        check_eq("post_rst_valid_count", valid_cnt - v0, 1);
        expect_byte("post_rst_data", 8'h7E);

        // Forced ticks while idle must be ignored.
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bps_force = 1'b1;
            @(negedge clk);
            bps_force = 1'b0;
            repeat (3) @(negedge clk);
        end
        check_eq("idle_tick_bps", {31'd0, bps_start}, 32'd0);
        check_eq("idle_tick_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("idle_tick_no_strobe", (valid_cnt - v0) + (err_cnt - e0), 0);
        check_eq("idle_tick_data", {24'd0, rx_data}, 32'h7E);

        check_eq("strobes_exclusive", both_cnt, 0);
        check_eq("no_extra_bytes", data_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
